// File: rtl/multirow_frame_sequencer.sv
// Frame-timing controller: sequences multi-row packets from the line buffers with v/h sync envelopes.
// Optional build macro FRAME_SEQ_CONTINUOUS_EN: self-restart the next frame after one IDLE cycle.
module multirow_frame_sequencer #(
    parameter int unsigned P_INPUT_ROWS_NUM = 5,
    parameter int unsigned P_IMAGE_WIDTH    = 256,
    parameter int unsigned P_IMAGE_HEIGHT   = 256,
    parameter int unsigned P_H_BLANK        = 16,
    parameter int unsigned P_V_PRE          = 4,
    parameter int unsigned P_V_POST         = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic        i_buf_ready,
    output logic        o_rd_en,
    output logic        o_v_async,
    output logic        o_h_async,
    output logic        o_remainder_signal,
    output logic [15:0] o_group_idx,
    output logic        o_busy,
    output logic        o_frame_done
);

    localparam int unsigned GROUPS     = (P_IMAGE_HEIGHT + P_INPUT_ROWS_NUM - 1) / P_INPUT_ROWS_NUM;
    localparam bit          HAS_REM    = (P_IMAGE_HEIGHT % P_INPUT_ROWS_NUM) != 0;
    localparam logic [15:0] LAST_GROUP = 16'(GROUPS - 1);
    localparam logic [15:0] LAST_PIXEL = 16'(P_IMAGE_WIDTH - 1);
    localparam logic [15:0] LAST_HB    = 16'(P_H_BLANK - 1);
    localparam logic [15:0] LAST_PRE   = 16'(P_V_PRE - 1);
    localparam logic [15:0] LAST_POST  = 16'(P_V_POST - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_V_PRE,
        S_WAIT_BUF,
        S_ACTIVE,
        S_H_BLANK,
        S_V_POST
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] cnt;
    logic [15:0] group_idx;
    logic [15:0] group_nxt;
    logic        h_q;
    logic        rem_q;
    logic        done_q;
    logic        done_nxt;
    logic        in_active;
    logic        last_group;
    logic        start_req;

    assign in_active  = (state == S_ACTIVE);
    assign last_group = (group_idx == LAST_GROUP);

`ifdef FRAME_SEQ_CONTINUOUS_EN
    // Armed by a completed frame; abort disarms so a restart needs i_start again.
    logic armed;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            armed <= 1'b0;
        end else if (i_abort) begin
            armed <= 1'b0;
        end else if (done_nxt) begin
            armed <= 1'b1;
        end else if (state == S_IDLE) begin
            armed <= 1'b0;
        end
    end

    assign start_req = i_start | armed;
`else
    assign start_req = i_start;
`endif

    always_comb begin
        state_nxt = state;
        group_nxt = group_idx;
        done_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                group_nxt = '0;
                if (start_req) state_nxt = S_V_PRE;
            end
            S_V_PRE: begin
                if (cnt == LAST_PRE) state_nxt = S_WAIT_BUF;
            end
            S_WAIT_BUF: begin
                if (i_buf_ready) state_nxt = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (cnt == LAST_PIXEL) state_nxt = last_group ? S_V_POST : S_H_BLANK;
            end
            S_H_BLANK: begin
                if (cnt == LAST_HB) begin
                    state_nxt = S_WAIT_BUF;
                    group_nxt = group_idx + 16'd1;
                end
            end
            S_V_POST: begin
                if (cnt == LAST_POST) begin
                    state_nxt = S_IDLE;
                    group_nxt = '0;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                group_nxt = '0;
            end
        endcase
        if (i_abort) begin
            state_nxt = S_IDLE;
            group_nxt = '0;
            done_nxt  = 1'b0;
        end
    end

    // Phase counter restarts on every state change so each state times its own dwell.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            group_idx <= '0;
            h_q       <= 1'b0;
            rem_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= (state_nxt != state) ? '0 : cnt + 16'd1;
            group_idx <= group_nxt;
            h_q       <= in_active & ~i_abort;
            rem_q     <= HAS_REM & in_active & last_group & ~i_abort;
            done_q    <= done_nxt;
        end
    end

    assign o_rd_en            = in_active;
    assign o_v_async          = (state != S_IDLE);
    assign o_busy             = (state != S_IDLE);
    assign o_h_async          = h_q;
    assign o_remainder_signal = rem_q;
    assign o_group_idx        = group_idx;
    assign o_frame_done       = done_q;

endmodule

// File: tb/tb_multirow_frame_sequencer.sv
// Bench for multirow_frame_sequencer: per-cycle comparison against a timeline built from the frame rules.
module tb_multirow_frame_sequencer;

    localparam int R     = 5;
    localparam int W     = 256;
    localparam int PH    = 16;
    localparam int PV    = 4;
    localparam int PVP   = 4;
    localparam int TLMAX = 16384;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        a_start, a_abort, a_buf;
    logic        b_start, b_abort, b_buf;
    logic        a_rd, a_v, a_h, a_rem, a_busy, a_done;
    logic        b_rd, b_v, b_h, b_rem, b_busy, b_done;
    logic [15:0] a_idx, b_idx;

    multirow_frame_sequencer u_dut (
        .i_clk(clk), .i_rst(rst), .i_start(a_start), .i_abort(a_abort), .i_buf_ready(a_buf),
        .o_rd_en(a_rd), .o_v_async(a_v), .o_h_async(a_h), .o_remainder_signal(a_rem),
        .o_group_idx(a_idx), .o_busy(a_busy), .o_frame_done(a_done)
    );

    multirow_frame_sequencer #(.P_IMAGE_HEIGHT(255)) u_dut255 (
        .i_clk(clk), .i_rst(rst), .i_start(b_start), .i_abort(b_abort), .i_buf_ready(b_buf),
        .o_rd_en(b_rd), .o_v_async(b_v), .o_h_async(b_h), .o_remainder_signal(b_rem),
        .o_group_idx(b_idx), .o_busy(b_busy), .o_frame_done(b_done)
    );

    typedef struct packed {
        logic        v, rd, h, rem, busy, done;
        logic [15:0] idx;
        logic        bufr, ab;
    } exp_t;

    exp_t obs_a, obs_b;
    assign obs_a = {a_v, a_rd, a_h, a_rem, a_busy, a_done, a_idx, 1'b0, 1'b0};
    assign obs_b = {b_v, b_rd, b_h, b_rem, b_busy, b_done, b_idx, 1'b0, 1'b0};

    exp_t tl [TLMAX];
    int   tl_len;
    int   abort_t;
    int   st [64];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input int t, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            if (errors <= 30) $error("FAIL %s at t=%0d: got %0h expected %0h", name, t, got, exp);
        end
    endtask

    task automatic compare(input int which, input exp_t e, input int t);
        exp_t o;
        o = (which == 0) ? obs_a : obs_b;
        chk("v_async", t, 16'(o.v), 16'(e.v));
        chk("rd_en", t, 16'(o.rd), 16'(e.rd));
        chk("h_async", t, 16'(o.h), 16'(e.h));
        chk("remainder", t, 16'(o.rem), 16'(e.rem));
        chk("busy", t, 16'(o.busy), 16'(e.busy));
        chk("frame_done", t, 16'(o.done), 16'(e.done));
        chk("group_idx", t, o.idx, e.idx);
    endtask

    task automatic drive(input int which, input logic s, input logic ab, input logic br);
        if (which == 0) begin
            a_start = s; a_abort = ab; a_buf = br;
        end else begin
            b_start = s; b_abort = ab; b_buf = br;
        end
    endtask

    // Expected output timeline; t counts edges after the one that samples i_start (t=1 is first v-high cycle).
    task automatic build(input int height, input int ab_g, input int ab_p);
        int  groups;
        bit  remf;
        int  t;
        groups  = (height + R - 1) / R;
        remf    = (height % R) != 0;
        abort_t = -1;
        for (int i = 0; i < TLMAX; i++) begin
            tl[i]      = '0;
            tl[i].bufr = 1'b1;
        end
        t = 1;
        for (int i = 0; i < PV; i++) begin
            tl[t].v = 1'b1; tl[t].busy = 1'b1; t++;
        end
        for (int g = 0; g < groups; g++) begin
            for (int s = 0; s <= st[g]; s++) begin
                tl[t].v = 1'b1; tl[t].busy = 1'b1; tl[t].idx = 16'(g);
                tl[t].bufr = (s == st[g]);
                t++;
            end
            for (int p = 0; p < W; p++) begin
                tl[t].v = 1'b1; tl[t].busy = 1'b1; tl[t].rd = 1'b1; tl[t].idx = 16'(g);
                if (g == ab_g && p == ab_p) begin
                    abort_t = t;
                    tl[t].ab = 1'b1;
                end
                t++;
            end
            for (int k = 0; k < ((g < groups - 1) ? PH : PVP); k++) begin
                tl[t].v = 1'b1; tl[t].busy = 1'b1; tl[t].idx = 16'(g); t++;
            end
        end
        tl[t].done = 1'b1;
        tl_len = t + 1;
        for (int i = 1; i < tl_len; i++) begin
            tl[i].h   = tl[i-1].rd;
            tl[i].rem = tl[i-1].rd && remf && (tl[i-1].idx == 16'(groups - 1));
        end
        if (abort_t >= 0) begin
            for (int i = abort_t + 1; i < TLMAX; i++) begin
                tl[i]      = '0;
                tl[i].bufr = 1'b1;
            end
            tl_len = abort_t + 3;
        end
    endtask

    task automatic run(input int which, input int last_t, input bit rand_start);
        logic s;
        for (int t = 1; t < tl_len && t <= last_t; t++) begin
            @(negedge clk);
            s = (t == 1) || (rand_start && tl[t-1].busy && ($urandom_range(0, 15) == 0));
            drive(which, s, tl[t-1].ab, tl[t-1].bufr);
            @(posedge clk); #1;
            compare(which, tl[t], t);
        end
        @(negedge clk);
        drive(which, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic post_frame(input int which);
        exp_t o;
        @(posedge clk); #1;
        o = (which == 0) ? obs_a : obs_b;
`ifdef FRAME_SEQ_CONTINUOUS_EN
        chk("restart_v", -1, 16'(o.v), 16'd1);
        chk("restart_busy", -1, 16'(o.busy), 16'd1);
        @(negedge clk);
        drive(which, 1'b0, 1'b1, 1'b1);
        @(posedge clk); #1;
        o = (which == 0) ? obs_a : obs_b;
        chk("abort_v", -1, 16'(o.v), 16'd0);
        @(negedge clk);
        drive(which, 1'b0, 1'b0, 1'b1);
`else
        chk("idle_v", -1, 16'(o.v), 16'd0);
        chk("idle_done", -1, 16'(o.done), 16'd0);
`endif
        @(posedge clk); #1;
        o = (which == 0) ? obs_a : obs_b;
        chk("stay_idle", -1, 16'(o.busy), 16'd0);
    endtask

    initial begin
        exp_t z;
        int   t_stop;
        z   = '0;
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 1'b1);
        drive(1, 1'b0, 1'b0, 1'b1);
        for (int g = 0; g < 64; g++) st[g] = 0;
        repeat (3) @(posedge clk);
        #1;
        compare(0, z, 0);
        compare(1, z, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        compare(0, z, 0);

        // clean frame, default geometry
        build(256, -1, -1);
        run(0, TLMAX, 1'b0);
        post_frame(0);

        // random buffer stalls, a forced 20-cycle stall before group 3, stray starts while busy
        for (int g = 0; g < 64; g++) st[g] = $urandom_range(0, 3);
        st[3] = 20;
        build(256, -1, -1);
        run(0, TLMAX, 1'b1);
        post_frame(0);

        // abort at pixel 100 of group 10
        for (int g = 0; g < 64; g++) st[g] = 0;
        build(256, 10, 100);
        run(0, TLMAX, 1'b0);

        // clean restart after abort, then asynchronous reset mid-packet of group 2
        build(256, -1, -1);
        t_stop = 1 + PV + 2 * (1 + W + PH) + 1 + 50;
        run(0, t_stop, 1'b0);
        #2 rst = 1'b1;
        #1 compare(0, z, -2);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        compare(0, z, -3);

        // exact multiple of the row count: no remainder group
        build(255, -1, -1);
        run(1, TLMAX, 1'b0);
        post_frame(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
